// File: rtl/fpu_wb_queue.sv
// fpu_wb_queue: merges fadd/fmul results into one FP register-file write port.
// Results are buffered in a small FIFO. When both units offer a result, a
// round-robin arbiter picks one. NaNs are canonicalised on entry, and the
// exception flags are accumulated into a sticky fflags register in
// writeback order.
module fpu_wb_queue #(
    parameter int N     = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       add_valid,
    input  logic [4:0]                 add_rd,
    input  logic [N-1:0]               add_data,
    input  logic [4:0]                 add_flags,
    output logic                       add_ready,
    input  logic                       mul_valid,
    input  logic [4:0]                 mul_rd,
    input  logic [N-1:0]               mul_data,
    input  logic [4:0]                 mul_flags,
    output logic                       mul_ready,
    output logic                       wb_valid,
    output logic [4:0]                 wb_rd,
    output logic [N-1:0]               wb_data,
    input  logic                       wb_ready,
    output logic [4:0]                 fflags,
    input  logic                       fflags_clr,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = (N == 64) ? 11 : 8;
    localparam int MW = N - 1 - EW;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [N-1:0]  QNAN    = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};

    logic [4:0]    rd_mem    [DEPTH];
    logic [N-1:0]  data_mem  [DEPTH];
    logic [4:0]    flags_mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [4:0]    fflags_q, fflags_d;
    // rr_q high means fmul wins the next tie (fadd was the last to enqueue)
    logic          rr_q, rr_d;

    logic          add_gnt, mul_gnt, space;
    logic          enq_add, enq_mul, enq, deq;
    logic [4:0]    in_rd, in_flags;
    logic [N-1:0]  in_raw, in_data;

    // Arbitration, back-pressure and the enqueue/dequeue decisions
    always_comb begin
        add_gnt   = add_valid && (!mul_valid || !rr_q);
        mul_gnt   = mul_valid && (!add_valid || rr_q);
        deq       = wb_valid && wb_ready;
        space     = (count_q < DEPTH_C) || deq;
        add_ready = rst && add_gnt && space;
        mul_ready = rst && mul_gnt && space;
        enq_add   = add_valid && add_ready;
        enq_mul   = mul_valid && mul_ready;
        enq       = enq_add || enq_mul;
    end

    // Select the winning result and replace any NaN by the canonical quiet NaN
    always_comb begin
        in_rd    = enq_add ? add_rd    : mul_rd;
        in_raw   = enq_add ? add_data  : mul_data;
        in_flags = enq_add ? add_flags : mul_flags;
        in_data  = in_raw;
        if ((&in_raw[N-2 -: EW]) && (|in_raw[MW-1:0]))
            in_data = QNAN;
    end

    // Next-state for pointers, occupancy, arbiter and sticky flags
    always_comb begin
        wr_ptr_d = enq ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = deq ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(enq) - CW'(deq);
        rr_d     = enq ? enq_add : rr_q;
        fflags_d = fflags_q;
        // clear takes effect before the dequeued entry's flags accrue
        if (deq)
            fflags_d = (fflags_clr ? 5'b0 : fflags_q) | flags_mem[rd_ptr_q];
        else if (fflags_clr)
            fflags_d = 5'b0;
    end

    // Control state with asynchronous reset discarding all buffered entries
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            fflags_q <= '0;
            rr_q     <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            fflags_q <= fflags_d;
            rr_q     <= rr_d;
        end
    end

    // Entry storage; contents are only observed when count is non-zero
    always_ff @(posedge clk) begin
        if (enq) begin
            rd_mem[wr_ptr_q]    <= in_rd;
            data_mem[wr_ptr_q]  <= in_data;
            flags_mem[wr_ptr_q] <= in_flags;
        end
    end

    // Head entry drives the write port; zero when the queue is empty
    always_comb begin
        wb_valid = (count_q != '0);
        wb_rd    = wb_valid ? rd_mem[rd_ptr_q]   : 5'b0;
        wb_data  = wb_valid ? data_mem[rd_ptr_q] : '0;
        fflags   = fflags_q;
        count    = count_q;
    end

endmodule

// File: tb/tb_fpu_wb_queue.sv
// Scoreboard bench for fpu_wb_queue: the expected entries are queued as results are accepted
module tb_fpu_wb_queue;

    localparam int N     = 32;
    localparam int DEPTH = 4;

    typedef struct {
        logic [4:0]   rd;
        logic [N-1:0] data;
        logic [4:0]   flags;
    } ent_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         add_valid = 1'b0, mul_valid = 1'b0;
    logic [4:0]   add_rd = '0, mul_rd = '0, add_flags = '0, mul_flags = '0;
    logic [N-1:0] add_data = '0, mul_data = '0;
    logic         add_ready, mul_ready;
    logic         wb_valid, wb_ready = 1'b0;
    logic [4:0]   wb_rd, fflags;
    logic [N-1:0] wb_data;
    logic         fflags_clr = 1'b0;
    logic [$clog2(DEPTH):0] count;

    fpu_wb_queue #(.N(N), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .add_valid(add_valid), .add_rd(add_rd), .add_data(add_data),
        .add_flags(add_flags), .add_ready(add_ready),
        .mul_valid(mul_valid), .mul_rd(mul_rd), .mul_data(mul_data),
        .mul_flags(mul_flags), .mul_ready(mul_ready),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_ready(wb_ready), .fflags(fflags), .fflags_clr(fflags_clr),
        .count(count)
    );

    always #5 clk = ~clk;

    // reference state
    ent_t       exp_q[$];
    logic [4:0] fflags_m = '0;
    bit         last_add = 1'b0;
    bit         a_v = 1'b0, m_v = 1'b0;
    ent_t       a_e, m_e;
    int         checks = 0, passes = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [N-1:0] canon(input logic [N-1:0] d);
        if (d[30:23] == 8'hff && d[22:0] != 23'd0) return 32'h7fc00000;
        return d;
    endfunction

    // One clock cycle: offer/hold results, predict readiness, record accepted entries
    task automatic cycle(input bit na, input logic [4:0] ard, input logic [N-1:0] ad,
                         input logic [4:0] af, input bit nm, input logic [4:0] mrd,
                         input logic [N-1:0] md, input logic [4:0] mf,
                         input bit wr, input bit clr);
        int  sz;
        bit  space, ga, gm, era, erm;
        @(negedge clk);
        if (!a_v && na) begin a_v = 1'b1; a_e.rd = ard; a_e.data = ad; a_e.flags = af; end
        if (!m_v && nm) begin m_v = 1'b1; m_e.rd = mrd; m_e.data = md; m_e.flags = mf; end
        add_valid = a_v; add_rd = a_e.rd; add_data = a_e.data; add_flags = a_e.flags;
        mul_valid = m_v; mul_rd = m_e.rd; mul_data = m_e.data; mul_flags = m_e.flags;
        wb_ready = wr; fflags_clr = clr;
        #1;
        sz    = exp_q.size();
        space = (sz < DEPTH) || (sz != 0 && wr);
        ga    = a_v && (!m_v || !last_add);
        gm    = m_v && (!a_v || last_add);
        era   = ga && space;
        erm   = gm && space;
        check("count", 64'(count), 64'(sz));
        check("wb_valid", 64'(wb_valid), 64'(sz != 0));
        check("fflags", 64'(fflags), 64'(fflags_m));
        check("add_ready", 64'(add_ready), 64'(era));
        check("mul_ready", 64'(mul_ready), 64'(erm));
        if (era) begin
            exp_q.push_back('{rd: a_e.rd, data: canon(a_e.data), flags: a_e.flags});
            last_add = 1'b1; a_v = 1'b0;
        end else if (erm) begin
            exp_q.push_back('{rd: m_e.rd, data: canon(m_e.data), flags: m_e.flags});
            last_add = 1'b0; m_v = 1'b0;
        end
    endtask

    // Monitor: whenever the DUT presents a write that is taken, compare with the oldest expectation
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                if (wb_valid && wb_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_wb", 64'(wb_valid), 64'(0));
                    end else begin
                        e = exp_q.pop_front();
                        check("wb_rd", 64'(wb_rd), 64'(e.rd));
                        check("wb_data", 64'(wb_data), 64'(e.data));
                        fflags_m = (fflags_clr ? 5'b0 : fflags_m) | e.flags;
                    end
                end else if (fflags_clr) begin
                    fflags_m = 5'b0;
                end
            end
        end
    end

    function automatic logic [N-1:0] rand_data();
        case ($urandom_range(0, 5))
            0: return 32'h7fa00000;
            1: return 32'h7f800000;
            2: return 32'hffc00123;
            3: return 32'h7f800001;
            default: return $urandom();
        endcase
    endfunction

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++)
            cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        check("drain_empty", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        // reset state, with both units offering results
        add_valid = 1'b1; mul_valid = 1'b1;
        #2;
        check("rst_add_ready", 64'(add_ready), 64'(0));
        check("rst_mul_ready", 64'(mul_ready), 64'(0));
        check("rst_wb_valid", 64'(wb_valid), 64'(0));
        check("rst_count", 64'(count), 64'(0));
        check("rst_fflags", 64'(fflags), 64'(0));
        add_valid = 1'b0; mul_valid = 1'b0;
        #1 rst = 1'b1;

        // single fadd result straight through
        cycle(1, 5'd3, 32'h3f800000, 5'b0, 0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

        // both valid while stalled: alternating fill, then back-pressure when full
        for (int i = 0; i < 5; i++)
            cycle(1, 5'(i), 32'h40000000 + i, 5'b0, 1, 5'(16 + i), 32'h41000000 + i, 5'b0, 0, 0);
        // full with simultaneous enqueue and dequeue
        cycle(1, 5'd9, 32'h3f000000, 5'b0, 1, 5'd25, 32'h3e000000, 5'b0, 1, 0);
        drain();

        // signalling NaN canonicalised, flags accrue after writeback
        cycle(1, 5'd7, 32'h7fa00000, 5'b10000, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("nan_fflags", 64'(fflags), 64'(5'b10000));

        // clear together with dequeue keeps only the dequeued flags
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1, 5'd1, 32'h3f800000, 5'b00001, 1, 0);
        cycle(0, 0, 0, 0, 1, 5'd2, 32'h40400000, 5'b00100, 1, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("pre_clr_fflags", 64'(fflags), 64'(5'b00001));
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("clr_deq_fflags", 64'(fflags), 64'(5'b00100));

        // three entries buffered, then an asynchronous reset pulse mid-cycle
        for (int i = 0; i < 3; i++)
            cycle(1, 5'(10 + i), 32'h3f800000, 5'b00010, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        add_valid = 1'b1; mul_valid = 1'b1; wb_ready = 1'b0; fflags_clr = 1'b0;
        #3 rst = 1'b0;
        #1;
        check("arst_wb_valid", 64'(wb_valid), 64'(0));
        check("arst_count", 64'(count), 64'(0));
        check("arst_fflags", 64'(fflags), 64'(0));
        check("arst_wb_data", 64'(wb_data), 64'(0));
        check("arst_add_ready", 64'(add_ready), 64'(0));
        add_valid = 1'b0; mul_valid = 1'b0;
        exp_q.delete(); fflags_m = '0; last_add = 1'b0; a_v = 1'b0; m_v = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++)
            cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

        // randomized traffic
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 1), 5'($urandom()), rand_data(), 5'($urandom()),
                  $urandom_range(0, 1), 5'($urandom()), rand_data(), 5'($urandom()),
                  $urandom_range(0, 9) < 6, $urandom_range(0, 9) == 0);
        while (a_v || m_v)
            cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
